// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter fed by a small input FIFO. The frame format is fixed by parameters.
// Queued words are sent back-to-back with no idle gap between frames.
module uart_tx_fifo_cfg #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [LW-1:0]        lvl_q, lvl_d;
  logic                 full, empty, push, pop, bit_end;
  logic [DATA_BITS-1:0] head;

  assign full       = (lvl_q == LW'(FIFO_DEPTH));
  assign empty      = (lvl_q == '0);
  assign s_ready    = !full;
  assign push       = s_valid && !full;
  assign head       = mem[rd_q];
  assign bit_end    = (cnt_q == CW'(CPB - 1));
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_level = lvl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ (PARITY == 2);
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next frame when a word is waiting.
            if (!empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = (^head) ^ (PARITY == 2);
              state_d = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    lvl_d = lvl_q + LW'(push) - LW'(pop);

    // tx is registered, so drive it from the state being entered.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (lvl_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      lvl_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      lvl_q   <= lvl_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= s_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: four frame formats at 10 clocks per bit.
// Expected frames come from hand-written tables or from a frame-building reference model.
module tb_uart_tx_fifo_cfg;

  localparam int CPB = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      sv = '0;
  logic [7:0]      sd0 = '0, sd2 = '0, sd3 = '0;
  logic [6:0]      sd1 = '0;
  logic [3:0]      s_ready, tx, busy;
  logic [3:0][2:0] lvl;

  int ncmp = 0;
  int nerr = 0;
  logic [8:0] sbq[$];

  always #5 clk = ~clk;

  // 0: 8N1   1: 7E2   2: 8O1   3: 8E1
  uart_tx_fifo_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (.clk(clk), .rst_n(rst_n), .s_data(sd0),
    .s_valid(sv[0]), .s_ready(s_ready[0]), .tx(tx[0]), .busy(busy[0]), .fifo_level(lvl[0]));
  uart_tx_fifo_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(1),
    .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (.clk(clk), .rst_n(rst_n), .s_data(sd1),
    .s_valid(sv[1]), .s_ready(s_ready[1]), .tx(tx[1]), .busy(busy[1]), .fifo_level(lvl[1]));
  uart_tx_fifo_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (.clk(clk), .rst_n(rst_n), .s_data(sd2),
    .s_valid(sv[2]), .s_ready(s_ready[2]), .tx(tx[2]), .busy(busy[2]), .fifo_level(lvl[2]));
  uart_tx_fifo_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(1),
    .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (.clk(clk), .rst_n(rst_n), .s_data(sd3),
    .s_valid(sv[3]), .s_ready(s_ready[3]), .tx(tx[3]), .busy(busy[3]), .fifo_level(lvl[3]));

  function automatic int db_of(input int k);  return (k == 1) ? 7 : 8; endfunction
  function automatic int sb_of(input int k);  return (k == 1) ? 2 : 1; endfunction
  function automatic int par_of(input int k);
    case (k)
      0:       return 0;
      2:       return 2;
      default: return 1;
    endcase
  endfunction
  function automatic int frame_len(input int k);
    return 1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + sb_of(k);
  endfunction

  // Reference model: bit i of the result is the i-th serial bit on the line.
  function automatic logic [15:0] mk_frame(input int k, input logic [8:0] d);
    logic [15:0] f;
    int p, ones;
    f = '0; p = 1; ones = 0;
    for (int i = 0; i < db_of(k); i++) begin
      f[p] = d[i];
      ones += int'(d[i]);
      p++;
    end
    if (par_of(k) == 1) begin f[p] = (ones % 2 == 1); p++; end
    if (par_of(k) == 2) begin f[p] = (ones % 2 == 0); p++; end
    for (int i = 0; i < sb_of(k); i++) begin f[p] = 1'b1; p++; end
    return f;
  endfunction

  task automatic set_in(input int k, input logic v, input logic [8:0] d);
    sv[k] = v;
    case (k)
      0: sd0 = d[7:0];
      1: sd1 = d[6:0];
      2: sd2 = d[7:0];
      default: sd3 = d[7:0];
    endcase
  endtask

  task automatic push1(input int k, input logic [8:0] d);
    set_in(k, 1'b1, d);
    @(negedge clk);
    set_in(k, 1'b0, 9'h0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Waits up to maxw cycles for a start bit, then checks every cycle of every bit.
  task automatic check_frame(input int k, input logic [15:0] bits, input int nb,
                             input int maxw, input string name);
    int w, bad;
    w = 0;
    while (tx[k] !== 1'b0 && w < maxw) begin
      @(negedge clk);
      w++;
    end
    ncmp++;
    if (tx[k] !== 1'b0) begin
      nerr++;
      $display("FAIL %s start: tx=%b, required 0 within %0d cycles", name, tx[k], maxw);
      return;
    end
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < CPB; c++) begin
        if (tx[k] !== bits[b]) bad++;
        @(negedge clk);
      end
      ncmp++;
      if (bad != 0) begin
        nerr++;
        $display("FAIL %s bit %0d: tx wrong in %0d of %0d cycles, required %b",
                 name, b, bad, CPB, bits[b]);
      end
    end
  endtask

  task automatic check_idle(input int k, input string name);
    check(name, {tx[k], busy[k], 1'b0, lvl[k]}, {1'b1, 1'b0, 1'b0, 3'd0});
  endtask

  task automatic rand_run(input int k, input int n);
    sbq.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          int g, guard;
          logic [8:0] w;
          g = $urandom_range(0, 3);
          repeat (g) begin
            set_in(k, 1'b0, 9'($urandom));
            @(negedge clk);
          end
          w = 9'($urandom) & 9'((1 << db_of(k)) - 1);
          set_in(k, 1'b1, w);
          guard = 0;
          while (!s_ready[k] && guard < 1000) begin @(negedge clk); guard++; end
          @(negedge clk);
          sbq.push_back(w);
        end
        set_in(k, 1'b0, 9'h0);
      end
      begin
        for (int i = 0; i < n; i++) begin
          int w2;
          w2 = 0;
          while (tx[k] !== 1'b0 && w2 < 3000) begin @(negedge clk); w2++; end
          ncmp++;
          if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL rnd_queue k=%0d: frame %0d started with no word accepted", k, i);
          end else begin
            check_frame(k, mk_frame(k, sbq.pop_front()), frame_len(k), 0, "rnd_frame");
          end
        end
      end
    join
    check_idle(k, "rnd_idle_after");
  endtask

  typedef struct {
    int          k;
    logic [8:0]  data;
    logic [15:0] bits;
    int          nb;
    string       name;
  } vec_t;

  vec_t vecs[9];
  logic [8:0] t4w[6];

  initial begin
    vecs[0] = '{0, 9'h0A5, 16'b0000_0011_0100_1010, 10, "8N1_A5"};
    vecs[1] = '{0, 9'h000, 16'b0000_0010_0000_0000, 10, "8N1_00"};
    vecs[2] = '{0, 9'h0FF, 16'b0000_0011_1111_1110, 10, "8N1_FF"};
    vecs[3] = '{1, 9'h053, 16'b0000_0110_1010_0110, 11, "7E2_53"};
    vecs[4] = '{1, 9'h07F, 16'b0000_0111_1111_1110, 11, "7E2_7F"};
    vecs[5] = '{2, 9'h000, 16'b0000_0110_0000_0000, 11, "8O1_00"};
    vecs[6] = '{2, 9'h001, 16'b0000_0100_0000_0010, 11, "8O1_01"};
    vecs[7] = '{3, 9'h0FF, 16'b0000_0101_1111_1110, 11, "8E1_FF"};
    vecs[8] = '{3, 9'h001, 16'b0000_0110_0000_0010, 11, "8E1_01"};
    t4w = '{9'h11, 9'h22, 9'h33, 9'h44, 9'h55, 9'h66};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check_idle(k, "reset_state");
      check("reset_ready", 32'(s_ready[k]), 32'd1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames, one per table row
    for (int i = 0; i < 9; i++) begin
      push1(vecs[i].k, vecs[i].data);
      check_frame(vecs[i].k, vecs[i].bits, vecs[i].nb, 3, vecs[i].name);
      check_idle(vecs[i].k, "idle_after");
    end

    // Six words with s_valid held: FIFO fills, frames run back-to-back in order
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int guard;
          set_in(0, 1'b1, t4w[i]);
          guard = 0;
          while (!s_ready[0] && guard < 500) begin @(negedge clk); guard++; end
          @(negedge clk);
          if (i == 4) begin
            check("t4_level_full", 32'(lvl[0]), 32'd4);
            check("t4_ready_low", 32'(s_ready[0]), 32'd0);
          end
        end
        set_in(0, 1'b0, 9'h0);
      end
      begin
        for (int j = 0; j < 6; j++)
          check_frame(0, mk_frame(0, t4w[j]), 10, (j == 0) ? 5 : 0, "t4_frame");
      end
    join
    check_idle(0, "t4_idle_after");

    // Push on the same edge as the pop at level 1
    set_in(0, 1'b1, 9'h3C);
    @(negedge clk);
    check("t6_level_push", 32'(lvl[0]), 32'd1);
    set_in(0, 1'b1, 9'hC3);
    @(negedge clk);
    set_in(0, 1'b0, 9'h0);
    check("t6_level_pushpop", 32'(lvl[0]), 32'd1);
    check_frame(0, mk_frame(0, 9'h3C), 10, 0, "t6_frame_a");
    check_frame(0, mk_frame(0, 9'hC3), 10, 0, "t6_frame_b");
    check_idle(0, "t6_idle_after");

    // Reset in the middle of data bit 3 with two words queued
    set_in(0, 1'b1, 9'h5A);
    @(negedge clk);
    set_in(0, 1'b1, 9'h66);
    @(negedge clk);
    set_in(0, 1'b1, 9'h99);
    @(negedge clk);
    set_in(0, 1'b0, 9'h0);
    check("t5_level_queued", 32'(lvl[0]), 32'd2);
    repeat (43) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle(0, "t5_after_reset");
    check("t5_ready", 32'(s_ready[0]), 32'd1);
    rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      repeat (300) begin
        @(negedge clk);
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      end
      check("t5_quiet_cycles_bad", 32'(bad), 32'd0);
    end

    // Randomized traffic on every format
    for (int k = 0; k < 4; k++) rand_run(k, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
